// File: rtl/binary_to_bcd_param.sv
// binary_to_bcd_param
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It retires one input bit per clock. A conversion takes BIN_W shift cycles
//   plus one publish cycle.
//   Results saturate to all nines when the value does not fit in DIGITS digits.
//   A leading-zero mask is produced for display blanking.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   start      in   conversion request, accepted only while ready=1
//   binary_in  in   unsigned value, sampled when start is accepted
//   ready      out  idle, a start will be accepted
//   done       out  one-cycle pulse, results below are fresh
//   bcd_out    out  packed BCD, digit i at [4*i+3:4*i], digit 0 = units
//   overflow   out  last value exceeded 10^DIGITS-1
//   digit_nz   out  bit i set if digit i or any higher digit is nonzero, bit 0 forced
//
// State table
//   S_IDLE  | waiting for start, loads the shift registers on accept
//   S_SHIFT | one add-3 + shift per cycle, BIN_W cycles
//   S_DONE  | publish result (done pulses on the following edge)
module binary_to_bcd_param #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary_in,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_nz
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state;
    logic [BIN_W-1:0]  bin_sr;
    logic [BCD_W-1:0]  bcd_sr;
    logic              ovf_sr;
    logic [CNT_W-1:0]  cnt;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shift;
    logic [BIN_W-1:0]  bin_shift;
    logic [DIGITS-1:0] nz_next;
    logic              nz_acc;

    // Add-3 correction feeds the shift directly so both land in one register update.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
        end
        {bcd_shift, bin_shift} = {bcd_adj, bin_sr} << 1;
    end

    // Sweep from the top digit down. Once a nonzero digit is seen, every lower digit is shown.
    always_comb begin
        nz_acc  = 1'b0;
        nz_next = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nz_acc     = nz_acc | (|bcd_sr[4*d +: 4]);
            nz_next[d] = nz_acc;
        end
        nz_next[0] = 1'b1;
    end

    // done is registered and lands while the FSM is already back in IDLE.
    // Masking ready with done keeps the block busy through the pulse cycle.
    assign ready = (state == S_IDLE) && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            ovf_sr   <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            digit_nz <= {{(DIGITS-1){1'b0}}, 1'b1};
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && ready) begin
                        bin_sr <= binary_in;
                        bcd_sr <= '0;
                        ovf_sr <= 1'b0;
                        cnt    <= CNT_LOAD;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_sr <= bcd_shift;
                    bin_sr <= bin_shift;
                    // A carry out of the top digit means the value needs more than DIGITS digits.
                    ovf_sr <= ovf_sr | bcd_adj[BCD_W-1];
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state <= S_DONE;
                end
                S_DONE: begin
                    done     <= 1'b1;
                    overflow <= ovf_sr;
                    if (ovf_sr) begin
                        bcd_out  <= {DIGITS{4'h9}};
                        digit_nz <= '1;
                    end else begin
                        bcd_out  <= bcd_sr;
                        digit_nz <= nz_next;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_param.sv
// Testbench for binary_to_bcd_param.
// Three configurations share one clock and reset: 32/10, 32/3 and 20/7.
// An acceptance process pushes expected results, computed with decimal arithmetic, into per-instance queues.
// A monitor pops and compares whenever done pulses.
module tb_binary_to_bcd_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        st32 = 1'b0, st3 = 1'b0, st20 = 1'b0;
    logic [31:0] b32 = '0, b3 = '0;
    logic [19:0] b20 = '0;

    logic        rdy32, dn32, ovf32;
    logic [39:0] bcd32;
    logic [9:0]  nz32;

    logic        rdy3, dn3, ovf3;
    logic [11:0] bcd3;
    logic [2:0]  nz3;

    logic        rdy20, dn20, ovf20;
    logic [27:0] bcd20;
    logic [6:0]  nz20;

    binary_to_bcd_param #(.BIN_W(32), .DIGITS(10)) u32 (
        .clk(clk), .rst(rst), .start(st32), .binary_in(b32),
        .ready(rdy32), .done(dn32), .bcd_out(bcd32), .overflow(ovf32), .digit_nz(nz32));

    binary_to_bcd_param #(.BIN_W(32), .DIGITS(3)) u3 (
        .clk(clk), .rst(rst), .start(st3), .binary_in(b3),
        .ready(rdy3), .done(dn3), .bcd_out(bcd3), .overflow(ovf3), .digit_nz(nz3));

    binary_to_bcd_param #(.BIN_W(20), .DIGITS(7)) u20 (
        .clk(clk), .rst(rst), .start(st20), .binary_in(b20),
        .ready(rdy20), .done(dn20), .bcd_out(bcd20), .overflow(ovf20), .digit_nz(nz20));

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  nz;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q3[$];
    exp_t q20[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: decimal digits by repeated division, saturation when value >= 10^d.
    function automatic exp_t model(input longint unsigned v, input int d, input int done_cyc);
        exp_t            e;
        longint unsigned lim;
        longint unsigned t;
        int              hi;
        e.bcd = '0;
        e.nz  = '0;
        e.ovf = 1'b0;
        e.cyc = done_cyc;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        if (v >= lim) begin
            e.ovf = 1'b1;
            for (int i = 0; i < d; i++) begin
                e.bcd[4*i +: 4] = 4'h9;
                e.nz[i]         = 1'b1;
            end
        end else begin
            t  = v;
            hi = 0;
            for (int i = 0; i < d; i++) begin
                e.bcd[4*i +: 4] = 4'(t % 10);
                if ((t % 10) != 0) hi = i;
                t = t / 10;
            end
            for (int i = 0; i <= hi; i++) e.nz[i] = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic cmp(input string nm, input logic [39:0] bcd, input logic ovf,
                       input logic [9:0] nz, input exp_t e);
        check({nm, " bcd_out"},  64'(bcd), 64'(e.bcd));
        check({nm, " overflow"}, 64'(ovf), 64'(e.ovf));
        check({nm, " digit_nz"}, 64'(nz),  64'(e.nz));
        check({nm, " done cycle"}, 64'(cyc), 64'(e.cyc));
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Acceptance: the edge where start && ready is E0; done is due after edge E0+BIN_W+1.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (st32 && rdy32) q32.push_back(model(64'(b32), 10, cyc + 33));
            if (st3  && rdy3)  q3.push_back(model(64'(b3),   3, cyc + 33));
            if (st20 && rdy20) q20.push_back(model(64'(b20),  7, cyc + 21));
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (dn32) begin
                if (q32.size() == 0) flag("u32 done with no accepted start");
                else cmp("u32", bcd32, ovf32, nz32, q32.pop_front());
            end else if (q32.size() > 0 && cyc > q32[0].cyc) begin
                flag("u32 done missing");
                void'(q32.pop_front());
            end

            if (dn3) begin
                if (q3.size() == 0) flag("u3 done with no accepted start");
                else cmp("u3", {28'd0, bcd3}, ovf3, {7'd0, nz3}, q3.pop_front());
            end else if (q3.size() > 0 && cyc > q3[0].cyc) begin
                flag("u3 done missing");
                void'(q3.pop_front());
            end

            if (dn20) begin
                if (q20.size() == 0) flag("u20 done with no accepted start");
                else cmp("u20", {12'd0, bcd20}, ovf20, {3'd0, nz20}, q20.pop_front());
            end else if (q20.size() > 0 && cyc > q20[0].cyc) begin
                flag("u20 done missing");
                void'(q20.pop_front());
            end
        end
    end

    task automatic chk_rst(input string nm, input logic rdy, input logic dn,
                           input logic [63:0] bcd, input logic ovf, input logic [63:0] nz);
        check({nm, " reset ready"},    64'(rdy), 64'd1);
        check({nm, " reset done"},     64'(dn),  64'd0);
        check({nm, " reset bcd_out"},  bcd,      64'd0);
        check({nm, " reset overflow"}, 64'(ovf), 64'd0);
        check({nm, " reset digit_nz"}, nz,       64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rdy32 && rdy3 && rdy20 && q32.size() == 0 && q3.size() == 0 && q20.size() == 0)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) flag("timeout waiting for idle");
    endtask

    // Start the 32/10 instance and count the cycles ready stays low afterwards.
    task automatic go32(input logic [31:0] v);
        int n = 0;
        wait_idle();
        @(negedge clk);
        st32 = 1'b1;
        b32  = v;
        @(negedge clk);
        st32 = 1'b0;
        while (!rdy32 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("u32 ready-low cycles", 64'(n), 64'd34);
    endtask

    task automatic go3(input logic [31:0] v);
        int n = 0;
        @(negedge clk);
        while (!rdy3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) flag("u3 ready timeout");
        st3 = 1'b1;
        b3  = v;
        @(negedge clk);
        st3 = 1'b0;
    endtask

    task automatic go20(input logic [19:0] v);
        int n = 0;
        @(negedge clk);
        while (!rdy20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) flag("u20 ready timeout");
        st20 = 1'b1;
        b20  = v;
        @(negedge clk);
        st20 = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        longint unsigned p;
        logic [31:0] r32;
        logic [19:0] r20;

        repeat (3) @(negedge clk);
        chk_rst("u32", rdy32, dn32, 64'(bcd32), ovf32, 64'(nz32));
        chk_rst("u3",  rdy3,  dn3,  64'(bcd3),  ovf3,  64'(nz3));
        chk_rst("u20", rdy20, dn20, 64'(bcd20), ovf20, 64'(nz20));
        rst = 1'b0;

        go32(32'd0);
        go32(32'hFFFF_FFFF);
        go32(32'd1_000_000_007);
        wait_idle();

        go3(32'd255);
        go3(32'd7);
        go3(32'd999);
        go3(32'd1000);
        go3(32'd0);
        wait_idle();

        // start held high; binary_in changes mid-conversion and must not disturb it
        @(negedge clk);
        st3 = 1'b1;
        b3  = 32'd123;
        @(negedge clk);
        b3 = 32'd456;
        n = 0;
        while (!rdy3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) flag("u3 ready timeout (held start)");
        @(negedge clk);
        st3 = 1'b0;
        wait_idle();

        // reset in the middle of a conversion
        @(negedge clk);
        st3 = 1'b1;
        b3  = 32'd500;
        @(negedge clk);
        st3 = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_rst("u3 mid-conversion", rdy3, dn3, 64'(bcd3), ovf3, 64'(nz3));
        q3.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        go3(32'd42);
        wait_idle();

        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    k = int'($urandom_range(0, 3));
                    case (k)
                        0: r20 = 20'($urandom);
                        1: r20 = 20'($urandom_range(0, 99));
                        2: r20 = 20'hFFFFF - 20'($urandom_range(0, 15));
                        default: begin
                            p = 1;
                            repeat ($urandom_range(1, 6)) p = p * 10;
                            r20 = 20'(p - 64'($urandom_range(0, 1)));
                        end
                    endcase
                    go20(r20);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 1) == 0) r32 = 32'($urandom_range(0, 1100));
                    else r32 = $urandom;
                    go3(r32);
                end
            end
        join
        wait_idle();

        check("u32 queue drained", 64'(q32.size()), 64'd0);
        check("u3 queue drained",  64'(q3.size()),  64'd0);
        check("u20 queue drained", 64'(q20.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
